// File: rtl/pwm_ramp_ctrl.sv
// Soft-start duty sequencer for the 0..99-step PWM generator: ramp up, hold, ramp down.
// Define PWM_RAMP_LOOP_EN to repeat the up/hold/down cycle until stop or rst.
module pwm_ramp_ctrl #(
    parameter int DUTY_MAX     = 99,
    parameter int HOLD_PERIODS = 50,
    parameter int HOLD_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] target,
    input  logic [3:0] step,
    input  logic       period_done,
    output logic [6:0] duty,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } state_t;

    localparam logic [6:0]        DMAX      = 7'(DUTY_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    state_t            st;
    logic [6:0]        tgt;
    logic [3:0]        stp;
    logic [HOLD_W-1:0] hold_cnt;
    logic [6:0]        up_next;
    logic [6:0]        down_next;
    logic              ramp_end;
`ifdef PWM_RAMP_LOOP_EN
    logic              exit_req;
`endif

    // Sum is formed 8 bits wide so a large step near the top cannot wrap.
    function automatic logic [6:0] ramp_up(input logic [6:0] d, input logic [3:0] s,
                                           input logic [6:0] lim);
        logic [7:0] sum;
        sum = {1'b0, d} + {4'b0000, s};
        return (sum > {1'b0, lim}) ? lim : sum[6:0];
    endfunction

    function automatic logic [6:0] ramp_down(input logic [6:0] d, input logic [3:0] s);
        return (d > {3'b000, s}) ? (d - {3'b000, s}) : 7'd0;
    endfunction

    assign up_next   = ramp_up(duty, stp, tgt);
    assign down_next = ramp_down(duty, stp);
    // A DOWN entered with duty already 0 (zero target, or stop right after start) ends at once.
    assign ramp_end  = (duty == 7'd0) || (period_done && (down_next == 7'd0));
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            duty     <= 7'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tgt      <= 7'd0;
            stp      <= 4'd1;
            hold_cnt <= '0;
`ifdef PWM_RAMP_LOOP_EN
            exit_req <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (start && !stop) begin
                        tgt  <= (target > DMAX) ? 7'd0 : target;
                        stp  <= (step == 4'd0) ? 4'd1 : step;
                        st   <= UP;
                        busy <= 1'b1;
`ifdef PWM_RAMP_LOOP_EN
                        exit_req <= 1'b0;
`endif
                    end
                end
                UP: begin
                    if (stop) begin
                        st <= DOWN;
`ifdef PWM_RAMP_LOOP_EN
                        exit_req <= 1'b1;
`endif
                    end else if (duty == tgt) begin
                        st       <= HOLD;
                        hold_cnt <= '0;
                    end else if (period_done) begin
                        duty <= up_next;
                        if (up_next == tgt) begin
                            st       <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        st <= DOWN;
`ifdef PWM_RAMP_LOOP_EN
                        exit_req <= 1'b1;
`endif
                    end else if (period_done) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            st <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (period_done) begin
                        duty <= down_next;
                    end
                    if (ramp_end) begin
                        done <= 1'b1;
`ifdef PWM_RAMP_LOOP_EN
                        if (exit_req) begin
                            st   <= IDLE;
                            busy <= 1'b0;
                        end else begin
                            st <= UP;
                        end
`else
                        st   <= IDLE;
                        busy <= 1'b0;
`endif
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
